// File: rtl/tf_address_sequencer_pkg.sv
// tf_address_sequencer_pkg
// Shared definitions for the twiddle-factor address sequencer:
//   - state_e   : sequencer FSM state encoding (IDLE/RUN/GAP/DONE)
//   - MODE_*    : transform direction encoding carried on mode_intt
//   - clog2()   : ceiling log2, used for derived port and counter widths
package tf_address_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic MODE_NTT  = 1'b0;
  localparam logic MODE_INTT = 1'b1;

  // Ceiling log2 of a positive integer (clog2(1) = 0).
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((32'sd1 << r) < v) begin
      r = r + 32'sd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/tf_address_sequencer_lane.sv
// tf_lane_addr
// Combinational twiddle ROM address for one butterfly lane.
// Ports:
//   s    in  STAGE_W  current stage index
//   j    in  ADDR_W   butterfly index within the stage
//   mode in  1        MODE_NTT / MODE_INTT
//   addr out ADDR_W   twiddle ROM address
// NTT : (2^s - 1) + k          INTT : (2^(s+1) - 2) - k      with k = j >> (LOGN-1-s)
module tf_lane_addr
  import tf_address_sequencer_pkg::*;
#(
  parameter int LOGN    = 10,
  parameter int ADDR_W  = LOGN,
  parameter int STAGE_W = clog2(LOGN)
) (
  input  logic [STAGE_W-1:0] s,
  input  logic [ADDR_W-1:0]  j,
  input  logic               mode,
  output logic [ADDR_W-1:0]  addr
);

  logic [STAGE_W-1:0] sh_s;
  logic [ADDR_W-1:0]  k_s;
  logic [ADDR_W-1:0]  pow_s;
  logic [ADDR_W-1:0]  ntt_s;
  logic [ADDR_W-1:0]  intt_s;

  // Address arithmetic. Everything is kept at ADDR_W bits: 2^(s+1) can wrap
  // to 0 on the last stage, but the final INTT result is always in
  // [0, 2^LOGN-2], so modular arithmetic still gives the exact value.
  always_comb begin
    sh_s   = STAGE_W'(LOGN - 1) - s;
    k_s    = j >> sh_s;
    pow_s  = ADDR_W'(1'b1) << s;
    ntt_s  = pow_s - ADDR_W'(1'b1) + k_s;
    intt_s = (pow_s << 1'b1) - ADDR_W'(2'd2) - k_s;
    if (mode == MODE_INTT) begin
      addr = intt_s;
    end else begin
      addr = ntt_s;
    end
  end

endmodule

// File: rtl/tf_address_sequencer.sv
// tf_address_sequencer
// Self-sequencing twiddle ROM address generator for a radix-2 NTT/INTT core.
// Walks all LOGN stages of an N = 2^LOGN transform, presenting NBFU lane
// addresses per beat over valid/ready, with STAGE_GAP idle cycles between
// stages and a one-cycle done pulse at the end.
// Ports:
//   clk        in   clock
//   rst        in   asynchronous active-low reset
//   start      in   begin a transform (accepted only in IDLE)
//   mode_intt  in   0 = NTT, 1 = INTT, latched on accepted start
//   ready      in   downstream accepts the current beat
//   busy       out  accepted start through the DONE cycle
//   tf_valid   out  tf_addr / stage_out valid
//   tf_addr    out  lane b at [b*ADDR_W +: ADDR_W]
//   stage_out  out  stage index of the current beat
//   done       out  one-cycle pulse after the final beat is accepted
module tf_address_sequencer
  import tf_address_sequencer_pkg::*;
#(
  parameter int LOGN      = 10,
  parameter int NBFU      = 2,
  parameter int STAGE_GAP = 2,
  parameter int ADDR_W    = LOGN
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     mode_intt,
  input  logic                     ready,
  output logic                     busy,
  output logic                     tf_valid,
  output logic [NBFU*ADDR_W-1:0]   tf_addr,
  output logic [clog2(LOGN)-1:0]   stage_out,
  output logic                     done
);

  localparam int STAGE_W = clog2(LOGN);
  localparam int LNB     = clog2(NBFU);
  localparam int CYC     = (32'sd1 << LOGN) / (32'sd2 * NBFU);
  localparam int C_W     = ((LOGN - 1 - LNB) < 1) ? 1 : (LOGN - 1 - LNB);
  localparam int GAP_W   = (clog2(STAGE_GAP) < 1) ? 1 : clog2(STAGE_GAP);

  localparam logic [C_W-1:0]     LAST_C   = C_W'(CYC - 32'sd1);
  localparam logic [STAGE_W-1:0] LAST_S   = STAGE_W'(LOGN - 1);
  localparam logic [GAP_W-1:0]   LAST_GAP = GAP_W'(STAGE_GAP - 1);

  state_e                  state_r, state_n;
  logic                    mode_r, mode_n;
  logic [STAGE_W-1:0]      s_r, s_n;
  logic [C_W-1:0]          c_r, c_n;
  logic [GAP_W-1:0]        gap_r, gap_n;
  logic                    tf_valid_r, valid_n;
  logic                    busy_r, busy_n;
  logic                    done_r, done_n;
  logic [STAGE_W-1:0]      stage_r, stage_n;
  logic [NBFU*ADDR_W-1:0]  tf_addr_r, addr_n_s;

  // Beat currently being generated (fed to the lane address units).
  logic                    load_s;
  logic [STAGE_W-1:0]      gen_s_s;
  logic [C_W-1:0]          gen_c_s;
  logic                    gen_mode_s;
  logic [NBFU*ADDR_W-1:0]  lane_addr_s;

  // One address unit per butterfly lane; lane b handles j = c*NBFU + b.
  for (genvar b = 0; b < NBFU; b++) begin : g_lane
    logic [ADDR_W-1:0] j_s;
    assign j_s = (ADDR_W'(gen_c_s) << LNB) | ADDR_W'(b);
    tf_lane_addr #(
      .LOGN    (LOGN),
      .ADDR_W  (ADDR_W),
      .STAGE_W (STAGE_W)
    ) u_lane (
      .s    (gen_s_s),
      .j    (j_s),
      .mode (gen_mode_s),
      .addr (lane_addr_s[b*ADDR_W +: ADDR_W])
    );
  end

  // Output address register holds unless a new beat is loaded.
  assign addr_n_s = load_s ? lane_addr_s : tf_addr_r;

  // Next-state, counter and output-register logic. In RUN tf_valid is always
  // high, so the (!tf_valid || ready) advance rule reduces to ready.
  always_comb begin
    state_n    = state_r;
    mode_n     = mode_r;
    s_n        = s_r;
    c_n        = c_r;
    gap_n      = gap_r;
    valid_n    = tf_valid_r;
    busy_n     = busy_r;
    done_n     = 1'b0;
    load_s     = 1'b0;
    gen_s_s    = s_r;
    gen_c_s    = c_r;
    gen_mode_s = mode_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_n    = ST_RUN;
          mode_n     = mode_intt;
          gen_mode_s = mode_intt;
          s_n        = {STAGE_W{1'b0}};
          c_n        = {C_W{1'b0}};
          gen_s_s    = {STAGE_W{1'b0}};
          gen_c_s    = {C_W{1'b0}};
          load_s     = 1'b1;
          busy_n     = 1'b1;
        end else begin
          busy_n  = 1'b0;
          valid_n = 1'b0;
        end
      end
      ST_RUN: begin
        if (ready) begin
          if (c_r != LAST_C) begin
            c_n     = c_r + C_W'(1'b1);
            gen_c_s = c_r + C_W'(1'b1);
            load_s  = 1'b1;
          end else if (s_r == LAST_S) begin
            state_n = ST_DONE;
            valid_n = 1'b0;
            done_n  = 1'b1;
          end else if (STAGE_GAP > 0) begin
            state_n = ST_GAP;
            valid_n = 1'b0;
            gap_n   = {GAP_W{1'b0}};
          end else begin
            s_n     = s_r + STAGE_W'(1'b1);
            c_n     = {C_W{1'b0}};
            gen_s_s = s_r + STAGE_W'(1'b1);
            gen_c_s = {C_W{1'b0}};
            load_s  = 1'b1;
          end
        end else begin
          state_n = ST_RUN;
        end
      end
      ST_GAP: begin
        // Gap length is independent of ready.
        if (gap_r == LAST_GAP) begin
          state_n = ST_RUN;
          s_n     = s_r + STAGE_W'(1'b1);
          c_n     = {C_W{1'b0}};
          gen_s_s = s_r + STAGE_W'(1'b1);
          gen_c_s = {C_W{1'b0}};
          load_s  = 1'b1;
        end else begin
          gap_n = gap_r + GAP_W'(1'b1);
        end
      end
      ST_DONE: begin
        state_n = ST_IDLE;
        busy_n  = 1'b0;
      end
      default: begin
        state_n = ST_IDLE;
        valid_n = 1'b0;
        busy_n  = 1'b0;
      end
    endcase
    if (load_s) begin
      valid_n = 1'b1;
      stage_n = gen_s_s;
    end else begin
      stage_n = stage_r;
    end
  end

  // State, counter and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= ST_IDLE;
      mode_r     <= MODE_NTT;
      s_r        <= {STAGE_W{1'b0}};
      c_r        <= {C_W{1'b0}};
      gap_r      <= {GAP_W{1'b0}};
      tf_valid_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      stage_r    <= {STAGE_W{1'b0}};
      tf_addr_r  <= {(NBFU*ADDR_W){1'b0}};
    end else begin
      state_r    <= state_n;
      mode_r     <= mode_n;
      s_r        <= s_n;
      c_r        <= c_n;
      gap_r      <= gap_n;
      tf_valid_r <= valid_n;
      busy_r     <= busy_n;
      done_r     <= done_n;
      stage_r    <= stage_n;
      tf_addr_r  <= addr_n_s;
    end
  end

  assign busy      = busy_r;
  assign tf_valid  = tf_valid_r;
  assign tf_addr   = tf_addr_r;
  assign stage_out = stage_r;
  assign done      = done_r;

endmodule
